// File: rtl/coin_pkg.sv
// coin_pkg: shared coin code type, parameter defaults and priority encoder
package coin_pkg;
  typedef enum logic [1:0] {NONE, NICKEL, DIME, QUARTER} coin_t;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  // One-hot select {Q,D,N} to coin code, quarter has highest priority
  function automatic coin_t code_of(input logic [2:0] sel);
    return sel[2] ? QUARTER : sel[1] ? DIME : sel[0] ? NICKEL : NONE;
  endfunction
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchronizer, level debounce and rising-edge event for one coin sensor
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   raw      in  asynchronous bouncy sensor level
//   evt      out one-cycle pulse when the debounced level rises
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, deb_level, deb_prev;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      deb_level <= 1'b0;
      deb_prev <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_prev <= deb_level;
      // level follows s2 only after it has disagreed for DEBOUNCE_CYCLES straight edges
      if (s2 != deb_level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_level <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
  assign evt = deb_level & ~deb_prev;
endmodule

// File: rtl/coin_front_end.sv
// coin_front_end: debounces three coin sensors, arbitrates coin events into a FIFO and issues spaced coin pulses
//   clk                          in  clock
//   rst_n                        in  asynchronous active-low reset
//   coin_n_raw/coin_d_raw/coin_q_raw in raw nickel/dime/quarter sensors
//   dis_i                        in  downstream FSM is dispensing; hold off issue
//   N, D, Q                      out registered one-cycle coin pulses
//   coin_rej                     out registered pulse: a coin event was dropped
//   fifo_full                    out FIFO holds FIFO_DEPTH entries
//   busy                         out anything pending, queued or being issued
module coin_front_end import coin_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_n_raw,
  input  logic coin_d_raw,
  input  logic coin_q_raw,
  input  logic dis_i,
  output logic N,
  output logic D,
  output logic Q,
  output logic coin_rej,
  output logic fifo_full,
  output logic busy
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [2:0] raw, ev, pend, grant, drop;
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic push, pop;
  coin_t mem [FIFO_DEPTH];
  coin_t head;
  assign raw = {coin_q_raw, coin_d_raw, coin_n_raw};
  for (genvar i = 0; i < 3; i++) begin : g_deb
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw[i]),
      .evt(ev[i])
    );
  end
  assign fifo_full = count == CW'(FIFO_DEPTH);
  // while full, nothing is granted so pending flags simply wait
  always_comb begin
    grant = 3'b000;
    if (!fifo_full)
      grant = pend[2] ? 3'b100 : pend[1] ? 3'b010 : pend[0] ? 3'b001 : 3'b000;
  end
  assign push = |grant;
  // issuing only when no pulse is out spaces coins at least two cycles apart
  assign pop = (count != '0) & ~dis_i & ~(N | D | Q);
  assign drop = ev & pend & ~grant;
  assign head = mem[rd];
  assign busy = (|pend) | (count != '0) | N | D | Q;
  always_ff @(posedge clk) begin
    if (push)
      mem[wr] <= code_of(grant);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 3'b000;
      wr <= '0;
      rd <= '0;
      count <= '0;
      N <= 1'b0;
      D <= 1'b0;
      Q <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | ev;
      coin_rej <= |drop;
      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr <= (wr == AW'(FIFO_DEPTH - 1)) ? '0 : wr + 1'b1;
      if (pop)
        rd <= (rd == AW'(FIFO_DEPTH - 1)) ? '0 : rd + 1'b1;
      N <= pop & (head == NICKEL);
      D <= pop & (head == DIME);
      Q <= pop & (head == QUARTER);
    end
  end
endmodule

// File: tb/tb_coin_front_end.sv
// tb_coin_front_end: randomized and directed checks of coin_front_end against a queue-based reference model
module tb_coin_front_end;
  localparam int DB = 4;
  localparam int FD = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  logic coin_n_raw = 1'b0, coin_d_raw = 1'b0, coin_q_raw = 1'b0, dis_i = 1'b0;
  logic N, D, Q, coin_rej, fifo_full, busy;
  logic [5:0] obs;
  int checks = 0, failures = 0;
  // reference model: index 0 nickel, 1 dime, 2 quarter
  logic [2:0] m_s1, m_s2, m_deb, m_prev, m_pend, m_out;
  logic m_rej;
  int m_run [3];
  logic [2:0] m_q [$];

  coin_front_end #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_n_raw(coin_n_raw), .coin_d_raw(coin_d_raw), .coin_q_raw(coin_q_raw),
    .dis_i(dis_i),
    .N(N), .D(D), .Q(Q), .coin_rej(coin_rej), .fifo_full(fifo_full), .busy(busy)
  );

  always #5 clk = ~clk;
  assign obs = {N, D, Q, coin_rej, fifo_full, busy};

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_prev = 0; m_pend = 0; m_out = 0; m_rej = 0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic [2:0] ev, grant;
    bit pop;
    ev = m_deb & ~m_prev;
    pop = m_q.size() > 0 && !dis_i && m_out == 0;
    grant = 0;
    if (m_q.size() < FD) grant = m_pend[2] ? 3'b100 : m_pend[1] ? 3'b010 : m_pend[0] ? 3'b001 : 3'b000;
    m_out = pop ? m_q.pop_front() : 3'b000;
    if (grant != 0) m_q.push_back(grant);
    m_rej = |(ev & m_pend & ~grant);
    m_pend = (m_pend & ~grant) | ev;
    m_prev = m_deb;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_s2 = m_s1;
    m_s1 = {coin_q_raw, coin_d_raw, coin_n_raw};
  endtask

  function automatic logic [5:0] mexp();
    logic f, b;
    f = m_q.size() == FD;
    b = (|m_pend) || (m_q.size() != 0) || (|m_out);
    return {m_out[0], m_out[1], m_out[2], m_rej, f, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL reset_immediate got=%b exp=000000", obs); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs, mexp()); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int dn = 0, de = 0, other = 0;
    for (int c = 1; c <= 40; c++) begin
      coin_d_raw = c <= 20;
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL latency_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (D) begin dn++; de = c; end
      if (N || Q || coin_rej) other++;
    end
    checks++;
    if (dn != 1 || de != DB + 5) begin failures++; $display("FAIL latency_pulse count=%0d edge=%0d exp count=1 edge=%0d", dn, de, DB + 5); end
    checks++;
    if (other != 0) begin failures++; $display("FAIL latency_other got=%0d exp=0", other); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      coin_n_raw = (c <= 10) && (((c - 1) / 2) % 2 == 0);
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (N || D || Q) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_simultaneous();
    int tn = 0, td = 0, tq = 0, rej = 0;
    for (int c = 1; c <= 40; c++) begin
      {coin_q_raw, coin_d_raw, coin_n_raw} = (c <= 15) ? 3'b111 : 3'b000;
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL simul_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (N) tn = c;
      if (D) td = c;
      if (Q) tq = c;
      if (coin_rej) rej++;
    end
    checks++;
    if (tq != DB + 5 || td != DB + 7 || tn != DB + 9)
      begin failures++; $display("FAIL simul_order q=%0d d=%0d n=%0d exp q=%0d d=%0d n=%0d", tq, td, tn, DB + 5, DB + 7, DB + 9); end
    checks++;
    if (rej != 0) begin failures++; $display("FAIL simul_rej got=%0d exp=0", rej); end
  endtask

  task automatic test_full();
    int qn = 0, last = 0, gap_bad = 0, idle_at = 0;
    dis_i = 1'b1;
    for (int c = 0; c < 85; c++) begin
      coin_q_raw = (c < 80) && (c % 16 < 8);
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL full_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
    end
    checks++;
    if (fifo_full !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL full_flag full=%b busy=%b exp full=1 busy=1", fifo_full, busy); end
    dis_i = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL full_drain cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (Q) begin
        if (qn > 0 && c - last != 2) gap_bad++;
        qn++; last = c;
      end
      if (!busy && idle_at == 0) idle_at = c;
    end
    checks++;
    if (qn != 5 || gap_bad != 0) begin failures++; $display("FAIL full_pulses count=%0d bad_gaps=%0d exp count=5 bad_gaps=0", qn, gap_bad); end
    checks++;
    if (idle_at != last + 1) begin failures++; $display("FAIL full_busy_fall at=%0d exp=%0d", idle_at, last + 1); end
  endtask

  task automatic test_reject();
    int rej = 0, nn = 0;
    dis_i = 1'b1;
    for (int c = 0; c < 101; c++) begin
      coin_n_raw = (c < 96) && (c % 16 < 8);
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL reject_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (coin_rej) rej++;
    end
    dis_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL reject_drain cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (N) nn++;
    end
    checks++;
    if (rej != 1 || nn != 5) begin failures++; $display("FAIL reject_counts rej=%0d n=%0d exp rej=1 n=5", rej, nn); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    dis_i = 1'b1;
    for (int c = 0; c < 53; c++) begin
      {coin_q_raw, coin_d_raw, coin_n_raw} = (c < 48 && c % 16 < 8) ? 3'b001 << (c / 16) : 3'b000;
      tick();
    end
    checks++;
    if (m_q.size() != 3 || obs !== mexp()) begin failures++; $display("FAIL midreset_setup queued=%0d got=%b exp=%b", m_q.size(), obs, mexp()); end
    model_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL midreset_immediate got=%b exp=000000", obs); end
    repeat (3) tick();
    rst_n = 1'b1;
    dis_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (N || D || Q) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin failures++; $display("FAIL midreset_after pulses=%0d busy=%b exp pulses=0 busy=0", pulses, busy); end
  endtask

  task automatic test_held_reset();
    int qn = 0;
    coin_q_raw = 1'b1;
    model_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      coin_q_raw = c < 20;
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL held_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
      if (Q) qn++;
    end
    checks++;
    if (qn != 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", qn); end
  endtask

  task automatic test_random();
    int hold [3];
    int dhold = 0;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          hold[i] = $urandom_range(1, 12);
          case (i)
            0: coin_n_raw = $urandom_range(0, 1);
            1: coin_d_raw = $urandom_range(0, 1);
            default: coin_q_raw = $urandom_range(0, 1);
          endcase
        end
        hold[i]--;
      end
      if (dhold == 0) begin dhold = $urandom_range(1, 25); dis_i = $urandom_range(0, 3) == 0; end
      dhold--;
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", c, obs, mexp()); end
    end
    {coin_q_raw, coin_d_raw, coin_n_raw} = 3'b000;
    dis_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", c, obs, mexp()); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_full();
    test_reject();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_front_end.md
COIN_FRONT_END -- requirements
Module: coin_front_end

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized sensor level must differ from the debounced level before the debounced level updates.
REQ-002 Parameter FIFO_DEPTH, default 4: coin FIFO entries; power of two.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 coin_n_raw, coin_d_raw, coin_q_raw  input  1 each  asynchronous coin sensors (nickel, dime, quarter); active-high, bouncy.
REQ-006 dis_i  input  1  dispense indication from the downstream vending FSM; combinational from its state.
REQ-007 N, D, Q  output  1 each  registered single-cycle coin pulses to the vending FSM; at most one high per cycle.
REQ-008 coin_rej  output  1  registered single-cycle pulse: a coin event was dropped.
REQ-009 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 busy  output  1  any pending flag set, FIFO non-empty, or any of N/D/Q high.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer; s2 reflects raw after 2 edges.
REQ-012 Debounce: the counter SHALL increment while s2 != deb_level and clear when equal; deb_level SHALL take s2 on the DEBOUNCE_CYCLES-th consecutive differing edge.
REQ-013 Coin event SHALL be deb_level rising (deb_level & ~deb_prev); falling edges produce nothing.
REQ-014 An event SHALL set the pending flag of its coin type on the next edge.
REQ-015 An event arriving while its type's pending flag is already set, and not cleared on that same edge, SHALL be dropped, with coin_rej asserted for one cycle.
REQ-016 Arbiter: each edge, if the FIFO is not full, the highest-priority pending flag (Q > D > N) SHALL be cleared and its code written to the FIFO; the others wait.
REQ-017 FIFO full: pending flags SHALL be held and never lost.
REQ-018 Issue: on an edge where the FIFO is non-empty, dis_i = 0, and N/D/Q are all 0, the head SHALL be popped and its one-hot pulse registered; otherwise N/D/Q SHALL be 0.
REQ-019 Consequence of REQ-018: at most one coin per 2 cycles, so no coin lands while the FSM is in a dispense state.
REQ-020 Simultaneous pop and write SHALL be allowed in one cycle; occupancy is unchanged and order is preserved.
REQ-021 FIFO order SHALL equal arbiter write order; pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-022 Latency (isolated coin, idle block, dis_i = 0): the pulse SHALL appear DEBOUNCE_CYCLES+5 edges after the first edge sampling the raw input high (9 at default).
REQ-023 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-024 rst_n low SHALL immediately clear synchronizers, debounce counters, deb_level, deb_prev, pending flags, FIFO pointers and occupancy, N, D, Q and coin_rej.
REQ-025 Reset mid-operation SHALL discard queued and pending coins without issuing pulses.
REQ-026 A sensor held high through reset release SHALL yield exactly one event after debounce.

Structure
REQ-027 Package coin_pkg SHALL hold the coin code type (NONE, NICKEL, DIME, QUARTER, 2 bits) and the DEBOUNCE_CYCLES and FIFO_DEPTH defaults.
REQ-028 Sub-module coin_debounce (synchronizer + debounce + rising-edge event) SHALL be instantiated once per sensor.
REQ-029 Arbiter, FIFO and issue logic SHALL live in coin_front_end; target size 120-400 RTL lines.

Verification
REQ-030 coin_d_raw high 20 cycles, dis_i = 0 -> D high exactly one cycle at edge 9; N, Q, coin_rej stay 0.
REQ-031 coin_n_raw toggling every 2 cycles for 10 cycles, then 0 -> no pulse on N/D/Q.
REQ-032 coin_n_raw, coin_d_raw, coin_q_raw rise together -> pulses Q, D, N in that order, each 2 cycles apart; no coin_rej.
REQ-033 Five quarters queued while dis_i is held 1 -> four FIFO entries with fifo_full = 1 and the fifth held pending; after dis_i drops, 5 Q pulses 2 cycles apart and busy falls after the last.
REQ-034 A second nickel event while the nickel pending flag is set and the FIFO is full -> coin_rej pulses once; 5 N pulses total instead of 6.
REQ-035 rst_n asserted with 3 coins queued -> all outputs 0 immediately, no pulses after release, busy = 0.
